// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bin2bcd_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [3:0] BCD_NINE = 4'h9;

  // Decimal digits needed to hold any bin_w-bit value: ceil(bin_w * log10(2)).
  function automatic int min_digits(input int bin_w);
    return (bin_w * 30103 + 99999) / 100000;
  endfunction

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit cell: add 3 to a BCD digit that is 5 or more.
module bcd_add3 (
  input  logic [3:0] d,
  output logic [3:0] q
);

  assign q = (d >= 4'd5) ? d + 4'd3 : d;

endmodule

// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble converter with periodic refresh and start/busy/valid
// handshake; saturates to all nines when the value exceeds DIGITS digits.
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int BIN_W    = 8,
  parameter int DIGITS   = 3,
  parameter int HOLD_CNT = 14000000
) (
  input  logic                  iCLK_50,
  input  logic                  iRST_n,
  input  logic [BIN_W-1:0]      iBIN,
  input  logic                  iSTART,
  input  logic                  iAUTO,
  output logic [4*DIGITS-1:0]   oBCD,
  output logic                  oOVF,
  output logic                  oVALID,
  output logic                  oBUSY
);

  localparam int BCD_W  = 4 * DIGITS;
  localparam int CNT_W  = $clog2(BIN_W + 1);
  localparam int HOLD_W = (HOLD_CNT > 1) ? $clog2(HOLD_CNT) : 1;
  // When DIGITS covers the full input range the sticky bit folds away.
  localparam bit OVF_POSSIBLE = DIGITS < min_digits(BIN_W);

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BIN_W);

  if (DIGITS < 1 || BIN_W < 1) begin : g_bad_cfg
    $error("bin2bcd_seq: BIN_W and DIGITS must both be at least 1");
  end

  // ---------------------------------------------------------------- hold timer
  logic tick;

  if (HOLD_CNT == 0) begin : g_no_hold
    assign tick = 1'b0;
  end else begin : g_hold
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_CNT - 1);
    localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);
    logic [HOLD_W-1:0] hold_cnt;

    always_ff @(posedge iCLK_50 or negedge iRST_n) begin
      if (!iRST_n)                hold_cnt <= '0;
      else if (hold_cnt == HOLD_MAX) hold_cnt <= '0;
      else                        hold_cnt <= hold_cnt + HOLD_ONE;
    end

    assign tick = iAUTO && (hold_cnt == HOLD_MAX);
  end

  // ------------------------------------------------------------------ datapath
  state_t            state;
  logic [BIN_W-1:0]  bin_sr;
  logic [BCD_W-1:0]  acc;
  logic [BCD_W-1:0]  adj;
  logic [BCD_W:0]    acc_sh;
  logic [CNT_W-1:0]  bit_cnt;
  logic              sticky;
  logic              sticky_nxt;
  logic              pending;
  logic              new_req;
  logic              request;

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_add3 u_add3 (
      .d (acc[4*g +: 4]),
      .q (adj[4*g +: 4])
    );
  end

  // Adjusted digits shift left one; bit BCD_W is the carry out of the top digit.
  assign acc_sh     = {adj, bin_sr[BIN_W-1]};
  assign sticky_nxt = sticky | (OVF_POSSIBLE & acc_sh[BCD_W]);

  assign new_req = iSTART | tick;
  assign request = new_req | pending;

  // ----------------------------------------------------------------------- fsm
  always_ff @(posedge iCLK_50 or negedge iRST_n) begin
    if (!iRST_n) begin
      state   <= IDLE;
      bin_sr  <= '0;
      acc     <= '0;
      bit_cnt <= '0;
      sticky  <= 1'b0;
      pending <= 1'b0;
      oBCD    <= '0;
      oOVF    <= 1'b0;
      oVALID  <= 1'b0;
      oBUSY   <= 1'b0;
    end else begin
      oVALID <= 1'b0;
      case (state)
        IDLE: begin
          if (request) begin
            bin_sr  <= iBIN;
            acc     <= '0;
            sticky  <= 1'b0;
            bit_cnt <= CNT_LOAD;
            pending <= 1'b0;
            oBUSY   <= 1'b1;
            state   <= SHIFT;
          end
        end

        SHIFT: begin
          if (new_req) pending <= 1'b1;
          bin_sr  <= bin_sr << 1;
          acc     <= acc_sh[BCD_W-1:0];
          sticky  <= sticky_nxt;
          bit_cnt <= bit_cnt - CNT_ONE;
          // Result is loaded from the final shift so it is visible during DONE.
          if (bit_cnt == CNT_ONE) begin
            state  <= DONE;
            oVALID <= 1'b1;
            oBUSY  <= 1'b0;
            if (sticky_nxt) begin
              oBCD <= {DIGITS{BCD_NINE}};
              oOVF <= 1'b1;
            end else begin
              oBCD <= acc_sh[BCD_W-1:0];
              oOVF <= 1'b0;
            end
          end
        end

        DONE: begin
          if (new_req) pending <= 1'b1;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed bench for bin2bcd_seq: a 3-digit instance with a short hold timer
// and a 2-digit instance with refresh disabled.
module tb_bin2bcd_seq;

  logic        clk = 1'b0;
  logic        a_rst, b_rst;
  logic [7:0]  a_bin, b_bin;
  logic        a_start, b_start, a_auto, b_auto;
  logic [11:0] a_bcd;
  logic [7:0]  b_bcd;
  logic        a_ovf, b_ovf, a_valid, b_valid, a_busy, b_busy;

  int errors = 0;
  int checks = 0;
  int ec     = 0;

  always #5 clk = ~clk;

  bin2bcd_seq #(.BIN_W(8), .DIGITS(3), .HOLD_CNT(4)) dut_a (
    .iCLK_50 (clk),   .iRST_n (a_rst),  .iBIN  (a_bin),   .iSTART (a_start),
    .iAUTO   (a_auto), .oBCD  (a_bcd),  .oOVF  (a_ovf),   .oVALID (a_valid),
    .oBUSY   (a_busy)
  );

  bin2bcd_seq #(.BIN_W(8), .DIGITS(2), .HOLD_CNT(0)) dut_b (
    .iCLK_50 (clk),   .iRST_n (b_rst),  .iBIN  (b_bin),   .iSTART (b_start),
    .iAUTO   (b_auto), .oBCD  (b_bcd),  .oOVF  (b_ovf),   .oVALID (b_valid),
    .oBUSY   (b_busy)
  );

  // Edges since dut_a reset release; ec%4 tracks the hold timer phase.
  always @(posedge clk or negedge a_rst) begin
    if (!a_rst) ec <= 0;
    else        ec <= ec + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic get_valid(input int sel);
    return (sel != 0) ? b_valid : a_valid;
  endfunction

  function automatic logic [31:0] get_bcd(input int sel);
    return (sel != 0) ? 32'(b_bcd) : 32'(a_bcd);
  endfunction

  task automatic tick1();
    @(posedge clk); #1;
  endtask

  task automatic count_valid(input int sel, input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      tick1();
      if (get_valid(sel)) n++;
    end
  endtask

  // Waits up to limit cycles for oVALID; returns cycles waited (limit+1 on timeout).
  task automatic wait_valid(input int sel, input int limit, output int n);
    n = 1;
    tick1();
    while (!get_valid(sel) && n <= limit) begin
      tick1();
      n++;
    end
  endtask

  task automatic conv(input string tag, input int sel, input logic [7:0] bin,
                      input logic [31:0] exp_bcd, input logic exp_ovf);
    int  n;
    logic busy;
    if (sel != 0) begin b_bin = bin; b_start = 1'b1; end
    else          begin a_bin = bin; a_start = 1'b1; end
    tick1();
    a_start = 1'b0;
    b_start = 1'b0;
    busy = (sel != 0) ? b_busy : a_busy;
    chk({tag, ".busy"}, 32'(busy), 32'd1);
    n = 1;
    while (!get_valid(sel) && n < 40) begin
      tick1();
      n++;
    end
    chk({tag, ".lat"}, n, 32'd9);
    chk({tag, ".bcd"}, get_bcd(sel), exp_bcd);
    chk({tag, ".ovf"}, 32'((sel != 0) ? b_ovf : a_ovf), 32'(exp_ovf));
    tick1();
    chk({tag, ".vdrop"}, 32'(get_valid(sel)), 32'd0);
  endtask

  initial begin
    int n;
    a_rst = 1'b0; b_rst = 1'b0;
    a_bin = '0; b_bin = '0;
    a_start = 1'b0; b_start = 1'b0; a_auto = 1'b0; b_auto = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    a_rst = 1'b1; b_rst = 1'b1;
    #1;
    chk("rst.bcd",   32'(a_bcd),   32'd0);
    chk("rst.ovf",   32'(a_ovf),   32'd0);
    chk("rst.valid", 32'(a_valid), 32'd0);
    chk("rst.busy",  32'(a_busy),  32'd0);
    chk("rst.b_bcd", 32'(b_bcd),   32'd0);
    tick1();

    // Basic conversions, 3 digits.
    conv("c255", 0, 8'd255, 32'h255, 1'b0);
    conv("c0",   0, 8'd0,   32'h000, 1'b0);
    conv("c100", 0, 8'd100, 32'h100, 1'b0);

    // Two digits: fit, saturate, recover.
    conv("b99",  1, 8'd99,  32'h99, 1'b0);
    conv("b200", 1, 8'd200, 32'h99, 1'b1);
    conv("b42",  1, 8'd42,  32'h42, 1'b0);
    conv("b100", 1, 8'd100, 32'h99, 1'b1);

    // HOLD_CNT=0 never refreshes even with iAUTO high.
    b_auto = 1'b1;
    count_valid(1, 20, n);
    chk("b.noauto", n, 32'd0);
    b_auto = 1'b0;

    // Back-to-back: second request during SHIFT merges into one pending.
    a_bin = 8'd77; a_start = 1'b1;
    tick1();
    a_start = 1'b0;
    repeat (2) tick1();
    a_bin = 8'd88; a_start = 1'b1;
    tick1();
    a_start = 1'b0;
    tick1();
    a_start = 1'b1;
    tick1();
    a_start = 1'b0;
    wait_valid(0, 20, n);
    chk("b2b.first", get_bcd(0), 32'h077);
    wait_valid(0, 30, n);
    chk("b2b.gap", n, 32'd10);
    chk("b2b.second", get_bcd(0), 32'h088);
    count_valid(0, 25, n);
    chk("b2b.none", n, 32'd0);

    // Periodic refresh every 4 cycles keeps pending set: period is 10.
    a_bin = 8'd123; a_auto = 1'b1;
    wait_valid(0, 30, n);
    chk("auto.first", get_bcd(0), 32'h123);
    for (int i = 0; i < 3; i++) begin
      wait_valid(0, 30, n);
      chk("auto.gap", n, 32'd10);
      chk("auto.bcd", get_bcd(0), 32'h123);
    end
    a_auto = 1'b0;
    repeat (25) tick1();
    count_valid(0, 30, n);
    chk("auto.off", n, 32'd0);

    // Reset at SHIFT cycle 4 aborts the conversion.
    a_bin = 8'd255; a_start = 1'b1;
    tick1();
    a_start = 1'b0;
    repeat (3) tick1();
    a_rst = 1'b0;
    #1;
    chk("abort.bcd",  32'(a_bcd),  32'd0);
    chk("abort.busy", 32'(a_busy), 32'd0);
    chk("abort.ovf",  32'(a_ovf),  32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    a_rst = 1'b1;
    count_valid(0, 15, n);
    chk("abort.novalid", n, 32'd0);
    conv("c37", 0, 8'd37, 32'h037, 1'b0);

    // iSTART coincident with a timer tick while IDLE: a single conversion.
    n = 0;
    while ((ec % 4) != 3 && n < 8) begin
      tick1();
      n++;
    end
    a_bin = 8'd205; a_start = 1'b1; a_auto = 1'b1;
    tick1();
    a_start = 1'b0; a_auto = 1'b0;
    chk("coin.busy", 32'(a_busy), 32'd1);
    count_valid(0, 40, n);
    chk("coin.count", n, 32'd1);
    chk("coin.bcd", get_bcd(0), 32'h205);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bin2bcd_seq.md
Name: bin2bcd_seq

Overview:
- Parametrised, sequential binary-to-BCD converter for the sensor display path.
- Generalised successor to the fixed 8-bit, 3-digit display converter.
- Performs iterative double-dabble (shift/add-3) over BIN_W cycles.
- Supports both periodic refresh from a built-in hold timer and on-demand conversion via a start/busy/valid handshake.
- Flags overflow when the value does not fit in DIGITS decimal digits, and saturates the output.

Parameters:
- BIN_W, 8: width of the binary input.
- DIGITS, 3: number of BCD digits produced, 4 bits each.
- HOLD_CNT, 14000000: refresh period in iCLK_50 cycles. 0 disables periodic refresh.

Ports:
- iCLK_50  in  1  system clock, 50 MHz.
- iRST_n  in  1  asynchronous active-low reset.
- iBIN  in  BIN_W  binary value to convert. Sampled only on accept.
- iSTART  in  1  on-demand conversion request. Single-cycle pulse or level.
- iAUTO  in  1  1 = periodic refresh enabled, 0 = on-demand only.
- oBCD  out  4*DIGITS  registered BCD result. Digit k occupies bits [4k+3:4k]; digit 0 is the units digit.
- oOVF  out  1  1 = last result saturated.
- oVALID  out  1  one-cycle pulse when oBCD/oOVF update.
- oBUSY  out  1  1 while a conversion is in progress.

Behaviour:
- Reset (iRST_n low, asynchronous): FSM to IDLE; hold counter, pending flag, shift registers cleared; oBCD=0, oOVF=0, oVALID=0, oBUSY=0.
- Reset mid-conversion aborts it. oBCD returns to 0 and the interrupted result is never presented.
- Hold timer:
  - Counts 0..HOLD_CNT-1 continuously and wraps.
  - Emits a one-cycle tick when count == HOLD_CNT-1 and iAUTO=1.
  - The counter runs regardless of iAUTO.
  - HOLD_CNT=0: no tick is ever generated.
- Request = iSTART OR tick OR pending.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - On request: sample iBIN into the binary shift register, clear the BCD accumulator and the overflow sticky bit, load bit counter = BIN_W, clear pending, go to SHIFT.
  - oBUSY goes high the cycle after accept.
- SHIFT, once per cycle:
  - Each digit >= 5 gets +3 (combinational adjust).
  - Then {carry, BCD, bin} shifts left 1; the MSB of bin enters BCD bit 0.
  - A 1 shifted out of the top digit sets the overflow sticky bit.
  - Counter decrements. When it reaches 1 at the cycle's end, go to DONE.
  - SHIFT lasts exactly BIN_W cycles.
- DONE:
  - If sticky=0: oBCD <= accumulator, oOVF <= 0.
  - If sticky=1: oBCD <= all digits 4'h9, oOVF <= 1.
  - oVALID pulses high for this one cycle; oBUSY drops. Return to IDLE.
- Latency: oVALID is asserted BIN_W+1 cycles after the accept cycle. oBCD holds its value between conversions.
- Requests while busy:
  - A tick or iSTART arriving in SHIFT/DONE sets pending (one deep; further requests merge).
  - Pending is serviced on the first IDLE cycle, so IDLE lasts 1 cycle between back-to-back conversions.
  - iBIN is re-sampled at that accept.
- Simultaneous iSTART and tick in IDLE: exactly one conversion; pending stays 0.
- iBIN changing during a conversion has no effect on the current conversion.
- Width rules:
  - BCD accumulator is 4*DIGITS bits plus 1 carry bit.
  - All arithmetic is unsigned.
  - Adjust is applied per digit before the shift, never after the final shift.

Decomposition:
- Package bin2bcd_pkg holds:
  - state enum {IDLE, SHIFT, DONE};
  - function min_digits(BIN_W) = ceil(BIN_W*log10(2)), for elaboration check / assertion that DIGITS >= 1;
  - constant BCD_NINE = 4'h9.
- Sub-module bcd_add3: combinational 4-bit "if >=5 add 3" cell, instantiated DIGITS times via generate.
- Hold timer stays inline.

Test Plan:
- BIN_W=8, DIGITS=3, iAUTO=0: iSTART with iBIN=255 -> after 9 cycles oVALID pulse, oBCD=12'h255, oOVF=0. Then iBIN=0 -> oBCD=12'h000.
- BIN_W=8, DIGITS=2: iBIN=99 -> oBCD=8'h99, oOVF=0. iBIN=200 -> oBCD=8'h99, oOVF=1. Then iBIN=42 -> oBCD=8'h42, oOVF=0.
- HOLD_CNT=4, iAUTO=1, iBIN=123 held -> oVALID pulses at least every 10 cycles (tick every 4 plus pending service), each with oBCD=12'h123. With iAUTO=0, no further pulses.
- iSTART pulsed twice during SHIFT with iBIN changed 77->88 -> two results in order, 12'h077 then 12'h088. The second accept follows 1 IDLE cycle after the first oVALID.
- Assert iRST_n low at SHIFT cycle 4 of a 255 conversion -> oBCD=0, oBUSY=0, no oVALID. After release, iSTART with 37 -> oBCD=12'h037.
- iSTART coincident with tick in IDLE -> exactly one oVALID, no follow-on conversion.
